// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: opcodes, instruction field layout and
// the control FSM state encoding.
package cpu_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned OPR_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [OPC_W-1:0] OP_LOAD = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_HALT = 4'b0111;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'b1000;
  localparam logic [OPC_W-1:0] OP_JNZ  = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Control unit: PC, IR, zero flag and retire counter with the
// fetch/decode/execute FSM; branches and HALT resolve here, the rest go out.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned INSTR_W  = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  pc_addr,
  input  logic [INSTR_W-1:0] instr,
  output logic               exec_valid,
  output logic [OPC_W-1:0]   exec_opcode,
  output logic [OPR_W-1:0]   exec_operand,
  input  logic               exec_ready,
  input  logic               zero_in,
  input  logic               zero_we,
  output logic               last_zero,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retire_cnt
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                zero_q, zero_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                retire_en;
  logic [OPC_W-1:0]    ir_opc;
  logic [OPR_W-1:0]    ir_opr;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   br_tgt;

  assign ir_opc = ir_q[INSTR_W-1 -: OPC_W];
  assign ir_opr = ir_q[OPR_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(1);
  assign br_tgt = ADDR_W'(ir_opr);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= ADDR_W'(RESET_PC);
      ir_q     <= '0;
      zero_q   <= 1'b0;
      ret_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      zero_q   <= zero_d;
      ret_q    <= ret_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    zero_d    = zero_q;
    ret_d     = ret_q;
    retire_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = instr;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (ir_opc)
          OP_HALT: begin
            retire_en = 1'b1;
            state_d   = ST_HALTED;
          end
          OP_JZ: begin
            pc_d      = zero_q ? br_tgt : pc_inc;
            retire_en = 1'b1;
            state_d   = ST_FETCH;
          end
          OP_JNZ: begin
            pc_d      = !zero_q ? br_tgt : pc_inc;
            retire_en = 1'b1;
            state_d   = ST_FETCH;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        if (exec_ready) begin
          pc_d      = pc_inc;
          retire_en = 1'b1;
          if (zero_we) zero_d = zero_in;
          state_d   = ST_FETCH;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    // Counter saturates so a long-running program never wraps it
    if (retire_en && (ret_q != '1)) ret_d = ret_q + CNT_W'(1);

    valid_d  = (state_d == ST_EXEC);
    busy_d   = (state_d == ST_FETCH) || (state_d == ST_DECODE) || (state_d == ST_EXEC);
    halted_d = (state_d == ST_HALTED);
  end

  assign pc_addr      = pc_q;
  assign exec_valid   = valid_q;
  assign exec_opcode  = ir_opc;
  assign exec_operand = ir_opr;
  assign last_zero    = zero_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign retire_cnt   = ret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: ROM/datapath model, table-driven
// single-instruction vectors, scoreboard of dispatched instructions, corner sequences.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [3:0] pc_addr;
  logic [7:0] instr;
  logic       exec_valid;
  logic [3:0] exec_opcode;
  logic [3:0] exec_operand;
  logic       exec_ready = 1'b0;
  logic       zero_in;
  logic       zero_we;
  logic       last_zero;
  logic       busy;
  logic       halted;
  logic [7:0] retire_cnt;

  logic [7:0] rom [16];
  logic       zv  [16];
  logic       zw  [16];

  int errors = 0;
  int checks = 0;

  logic [7:0]  sb_q [$];
  int          stall_cfg = 0;
  logic [3:0]  stall_op = 4'h0;
  int          wait_cnt = 0;
  int          stall_total = 0;
  bit          stall_bad = 1'b0;
  bit          seen7 = 1'b0;
  logic [11:0] snap;

  fetch_sequencer #(.ADDR_W(4), .INSTR_W(8), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .run(run), .pc_addr(pc_addr), .instr(instr),
    .exec_valid(exec_valid), .exec_opcode(exec_opcode), .exec_operand(exec_operand),
    .exec_ready(exec_ready), .zero_in(zero_in), .zero_we(zero_we),
    .last_zero(last_zero), .busy(busy), .halted(halted), .retire_cnt(retire_cnt)
  );

  assign instr   = rom[pc_addr];
  assign zero_in = zv[pc_addr];
  assign zero_we = zw[pc_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Datapath model: drives exec_ready, checks dispatched instructions and stall stability
  always @(negedge clk) begin
    if (reset) begin
      wait_cnt   = 0;
      exec_ready = 1'b0;
    end else begin
      if (pc_addr == 4'd7) seen7 = 1'b1;
      if (exec_valid) begin
        if (wait_cnt == 0) snap = {pc_addr, exec_opcode, exec_operand};
        else if (snap !== {pc_addr, exec_opcode, exec_operand}) stall_bad = 1'b1;
        if (exec_opcode == stall_op && wait_cnt < stall_cfg) begin
          exec_ready = 1'b0;
          wait_cnt++;
          stall_total++;
        end else begin
          exec_ready = 1'b1;
          wait_cnt   = 0;
          if (sb_q.size() == 0) begin
            chk("sb_unexpected", 32'({exec_opcode, exec_operand}), 32'hFFFF);
          end else begin
            chk("sb_dispatch", 32'({exec_opcode, exec_operand}), 32'(sb_q.pop_front()));
          end
        end
      end else begin
        exec_ready = 1'($urandom_range(0, 1));
        wait_cnt   = 0;
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'h70;
      zv[i]  = 1'b0;
      zw[i]  = 1'b0;
    end
    sb_q.delete();
    stall_cfg = 0;
    stall_op  = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start_run();
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // cyc = k means the bench is in cycle N+k, where edge N sampled run
  task automatic wait_halt(input int max, output int cyc);
    cyc = 1;
    while (halted !== 1'b1 && cyc < max) begin
      step(1);
      cyc++;
    end
  endtask

  typedef struct {
    logic       zset;
    logic [7:0] op;
    logic [3:0] exp_pc;
    logic [7:0] exp_ret;
    int         exp_cyc;
    logic       exp_lz;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int cyc;

    vecs[0] = '{1'b1, 8'h85, 4'd5, 8'd3, 8, 1'b1};
    vecs[1] = '{1'b0, 8'h85, 4'd2, 8'd3, 8, 1'b0};
    vecs[2] = '{1'b0, 8'h96, 4'd6, 8'd3, 8, 1'b0};
    vecs[3] = '{1'b1, 8'h96, 4'd2, 8'd3, 8, 1'b1};
    vecs[4] = '{1'b1, 8'h33, 4'd2, 8'd3, 9, 1'b1};
    vecs[5] = '{1'b0, 8'h70, 4'd1, 8'd2, 6, 1'b0};
    vecs[6] = '{1'b1, 8'hF4, 4'd2, 8'd3, 9, 1'b1};

    // Reset and idle hold
    clear_prog();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("idle%0d", i),
          32'({pc_addr, busy, halted, exec_valid, last_zero, retire_cnt}), 32'h0);
    end

    // Table: ADD sets the flag, then one instruction under test, then HALT
    for (int v = 0; v < 7; v++) begin
      clear_prog();
      rom[0] = {OP_ADD, 4'h0};
      zv[0]  = vecs[v].zset;
      zw[0]  = 1'b1;
      rom[1] = vecs[v].op;
      sb_q.push_back({OP_ADD, 4'h0});
      if (vecs[v].op[7:4] != OP_HALT && vecs[v].op[7:4] != OP_JZ && vecs[v].op[7:4] != OP_JNZ)
        sb_q.push_back(vecs[v].op);
      do_reset();
      start_run();
      wait_halt(40, cyc);
      chk($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(vecs[v].exp_cyc));
      chk($sformatf("vec%0d_pc", v), 32'(pc_addr), 32'(vecs[v].exp_pc));
      chk($sformatf("vec%0d_retire", v), 32'(retire_cnt), 32'(vecs[v].exp_ret));
      chk($sformatf("vec%0d_zero", v), 32'(last_zero), 32'(vecs[v].exp_lz));
      chk($sformatf("vec%0d_sb_left", v), 32'(sb_q.size()), 32'd0);
    end

    // Straight-line program
    clear_prog();
    rom[0] = 8'h00; rom[1] = 8'h01; rom[2] = 8'h20; rom[3] = 8'h70;
    sb_q.push_back(8'h00); sb_q.push_back(8'h01); sb_q.push_back(8'h20);
    do_reset();
    start_run();
    wait_halt(40, cyc);
    chk("line_cycles", 32'(cyc), 32'd12);
    chk("line_retire", 32'(retire_cnt), 32'd4);
    chk("line_pc", 32'(pc_addr), 32'd3);
    chk("line_busy", 32'({busy, halted}), 32'b01);
    chk("line_sb_left", 32'(sb_q.size()), 32'd0);

    // Conditional branches
    clear_prog();
    rom[0] = 8'h20; zw[0] = 1'b1; zv[0] = 1'b0;
    rom[1] = 8'h87;
    rom[2] = 8'h30; zw[2] = 1'b1; zv[2] = 1'b1;
    rom[3] = 8'h97;
    rom[4] = 8'h88;
    sb_q.push_back(8'h20); sb_q.push_back(8'h30);
    do_reset();
    seen7 = 1'b0;
    start_run();
    wait_halt(60, cyc);
    chk("br_cycles", 32'(cyc), 32'd15);
    chk("br_pc", 32'(pc_addr), 32'd8);
    chk("br_retire", 32'(retire_cnt), 32'd6);
    chk("br_zero", 32'(last_zero), 32'd1);
    chk("br_seen7", 32'(seen7), 32'd0);
    chk("br_sb_left", 32'(sb_q.size()), 32'd0);

    // Backpressure: 4 stall cycles on ADD
    clear_prog();
    rom[0] = 8'h25;
    sb_q.push_back(8'h25);
    stall_cfg = 4;
    stall_op  = OP_ADD;
    do_reset();
    stall_total = 0;
    stall_bad   = 1'b0;
    start_run();
    wait_halt(40, cyc);
    chk("bp_cycles", 32'(cyc), 32'd10);
    chk("bp_stalls", 32'(stall_total), 32'd4);
    chk("bp_stable", 32'(stall_bad), 32'd0);
    chk("bp_pc", 32'(pc_addr), 32'd1);
    chk("bp_retire", 32'(retire_cnt), 32'd2);
    chk("bp_sb_left", 32'(sb_q.size()), 32'd0);

    // Branch to itself: 2-cycle loop
    clear_prog();
    rom[0] = 8'h90;
    do_reset();
    start_run();
    step(10);
    chk("loop_pc", 32'(pc_addr), 32'd0);
    chk("loop_retire", 32'(retire_cnt), 32'd5);
    chk("loop_busy", 32'({busy, halted, exec_valid}), 32'b100);

    // PC wrap and retire counter saturation
    clear_prog();
    for (int i = 0; i < 16; i++) rom[i] = {OP_LOAD, 4'(i)};
    for (int k = 0; k < 300; k++) sb_q.push_back({OP_LOAD, 4'(k % 16)});
    do_reset();
    start_run();
    step(48);
    chk("wrap_pc", 32'(pc_addr), 32'd0);
    chk("wrap_retire", 32'(retire_cnt), 32'd16);
    step(763 - 49);
    chk("sat_254", 32'(retire_cnt), 32'd254);
    step(3);
    chk("sat_255", 32'(retire_cnt), 32'd255);
    step(3);
    chk("sat_hold", 32'(retire_cnt), 32'd255);
    step(901 - 769);
    chk("sat_end", 32'(retire_cnt), 32'd255);
    chk("sat_pc", 32'(pc_addr), 32'd12);
    chk("sat_sb_left", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a stalled EXEC
    clear_prog();
    rom[0] = 8'h20; zw[0] = 1'b1; zv[0] = 1'b1;
    rom[1] = 8'h30;
    sb_q.push_back(8'h20);
    stall_cfg = 1000;
    stall_op  = OP_SUB;
    do_reset();
    start_run();
    cyc = 1;
    while (!(exec_valid === 1'b1 && exec_opcode == OP_SUB) && cyc < 30) begin
      step(1);
      cyc++;
    end
    chk("mid_in_exec", 32'({exec_valid, exec_opcode}), 32'({1'b1, OP_SUB}));
    chk("mid_zero_pre", 32'(last_zero), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_reset_outs",
        32'({exec_valid, busy, halted, last_zero, pc_addr, retire_cnt}), 32'h0);
    chk("mid_sb_left", 32'(sb_q.size()), 32'd0);
    stall_cfg = 0;
    sb_q.push_back(8'h20);
    sb_q.push_back(8'h30);
    step(2);
    start_run();
    wait_halt(40, cyc);
    chk("restart_cycles", 32'(cyc), 32'd9);
    chk("restart_pc", 32'(pc_addr), 32'd2);
    chk("restart_retire", 32'(retire_cnt), 32'd3);
    chk("restart_sb_left", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control unit for the 4-bit CPU: owns the program counter and the fetch/decode/execute state machine. It reads 8-bit instructions (4-bit opcode + 4-bit operand) from the combinational program ROM and resolves JZ, JNZ and HALT internally. All other opcodes go to the datapath over a valid/ready handshake. It sits between the instruction memory and the register file/ALU datapath, and holds the architectural zero flag used by conditional branches.

## Interface
Parameters:
- ADDR_W, 4, program counter / ROM address width (16 instructions)
- INSTR_W, 8, instruction width; opcode = [INSTR_W-1 -: 4], operand = [3:0]
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; all state and outputs take reset values on the first rising clk edge with reset=1
- run  in  1  level; starts execution from IDLE
- pc_addr  out  ADDR_W  address to instruction memory (the current PC)
- instr  in  INSTR_W  instruction word returned combinationally for pc_addr
- exec_valid  out  1  datapath instruction is presented
- exec_opcode  out  4  opcode of the instruction in IR
- exec_operand  out  4  operand of the instruction in IR
- exec_ready  in  1  datapath accepts and completes the instruction this cycle
- zero_in  in  1  datapath zero result
- zero_we  in  1  zero_in is valid; sampled only when exec_valid & exec_ready
- last_zero  out  1  architectural zero flag
- busy  out  1  high in FETCH, DECODE and EXEC
- halted  out  1  high in HALTED
- retire_cnt  out  8  count of retired instructions, saturating at 255

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALTED. Encoding is defined in the package.
- Reset values:
  - state=IDLE, pc=RESET_PC, IR=0
  - exec_valid=0, last_zero=0, busy=0, halted=0, retire_cnt=0
- IDLE: pc_addr=pc. Go to FETCH when run=1; otherwise stay.
- FETCH: IR <= instr (read at address pc). Go to DECODE.
- DECODE, by IR opcode:
  - HALT (0111): go to HALTED; pc unchanged; retire_cnt+1.
  - JZ (1000): pc <= last_zero ? operand : pc+1; retire_cnt+1; go to FETCH.
  - JNZ (1001): pc <= !last_zero ? operand : pc+1; retire_cnt+1; go to FETCH.
  - Any other opcode, including LOAD 0000, ADD 0010, SUB 0011 and the undefined codes: go to EXEC.
- EXEC: exec_valid=1; exec_opcode and exec_operand come from IR and stay stable while waiting.
  - On exec_ready=1: pc <= pc+1; retire_cnt+1; if zero_we then last_zero <= zero_in; go to FETCH.
  - On exec_ready=0: stay, with no change to any state.
- HALTED: terminal. run is ignored; only reset leaves it.
- PC arithmetic is modulo 2^ADDR_W: pc=15 with an increment gives 0, with no flag raised.
- Branch target equal to the current pc is legal and produces a 2-cycle loop.
- last_zero changes only in EXEC with a completing handshake, or on reset. Branches and HALT never modify it.
- retire_cnt holds at 255 once reached.
- Reset mid-operation, in any state including EXEC with exec_valid=1:
  - the state returns to IDLE on that edge and exec_valid is low in the next cycle;
  - a pending datapath transaction is abandoned, and the datapath must not rely on its completion.
- run deasserted after leaving IDLE has no effect; execution continues.

## Timing
- All outputs are registered state, or combinational decode of state/IR. There is no combinational path from exec_ready or zero_in to any output.
- pc_addr equals pc in every state; the ROM is asynchronous, so instr is sampled at the end of FETCH.
- Branch / HALT instruction: 2 cycles (FETCH, DECODE).
- Datapath instruction: 3 cycles with exec_ready=1 on the first EXEC cycle, plus one cycle per exec_ready=0 cycle.
- run sampled high in IDLE at edge N: FETCH in cycle N+1.
- The updated last_zero is visible at the DECODE of the next instruction (at least 2 cycles later).
- HALT decoded at edge N: halted=1 and busy=0 from cycle N+1.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants: OP_LOAD=4'b0000, OP_ADD=4'b0010, OP_SUB=4'b0011, OP_HALT=4'b0111, OP_JZ=4'b1000, OP_JNZ=4'b1001;
  - the state encoding constants;
  - opcode/operand field positions.
- The datapath and the bench use the same package.
- Single module, no sub-module: PC, IR, flag, counter and FSM are all small.

## Test plan
- Reset and idle hold:
  - Stimulus: reset 2 cycles, run=0 for 5 cycles.
  - Required: pc_addr=0, busy=0, halted=0, exec_valid=0, retire_cnt=0 throughout.
- Straight-line program [LOAD R0,0; LOAD R1,1; ADD; HALT] with exec_ready=1 and zero_we=0:
  - halted rises 12 cycles after run is sampled;
  - retire_cnt=4, pc=3;
  - exec_valid was seen for opcodes 0,0,2 in order.
- Conditional branch, program [ADD; JZ 7; SUB; JNZ 7; JZ 8; …; 8: HALT]:
  - ADD returns zero 0; SUB returns zero 1 (zero_we=1 on both).
  - Required: JZ 7 and JNZ 7 are not taken, JZ 8 is taken.
  - The ROM is never addressed at 7; halted occurs with pc=8.
- Backpressure: hold exec_ready=0 for 4 EXEC cycles on an ADD.
  - exec_valid and exec_opcode stay stable;
  - pc is unchanged until the handshake;
  - total instruction time is 7 cycles.
- Wrap and saturation:
  - 16 NOP-class (LOAD) instructions from pc=0 wrap to pc=0.
  - Run 300 instructions in total: retire_cnt saturates at 255.
- Reset mid-EXEC with exec_ready=0:
  - on the next edge state=IDLE, exec_valid=0, pc=0, last_zero=0;
  - a subsequent run restarts the program from address 0.
